// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Per-key 2-flop synchronizer and debounce FSM for active-low
//               pushbuttons. Produces a clean active-high level plus
//               single-cycle press/release pulses, all in the EXTCLK domain.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   EXTCLK      in   1         system clock, all logic on the rising edge
//   RST_n       in   1         synchronous active-low reset
//   KEY_n       in   NUM_KEYS  raw asynchronous pushbuttons (0 = pressed)
//   KEY_STATE   out  NUM_KEYS  debounced level (1 = pressed)
//   KEY_PRESS   out  NUM_KEYS  one-cycle pulse when KEY_STATE rises
//   KEY_RELEASE out  NUM_KEYS  one-cycle pulse when KEY_STATE falls
// ============================================================================
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                EXTCLK,
  input  logic                RST_n,
  input  logic [NUM_KEYS-1:0] KEY_n,
  output logic [NUM_KEYS-1:0] KEY_STATE,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Terminal count: the qualifying sample is the one seen while cnt sits here.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic             sync1_q;
      logic             sync2_q;
      state_e           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             key_state_q;
      logic             press_q;
      logic             release_q;

      // Synchronizer resets to the released level so no spurious press
      // is seen coming out of reset.
      always_ff @(posedge EXTCLK) begin
        if (!RST_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
        end else begin
          sync1_q <= KEY_n[k];
          sync2_q <= sync1_q;
        end
      end

      // Debounce FSM. Pulses default low every cycle and are raised only
      // on the accepting transition, so they are exactly one cycle wide.
      always_ff @(posedge EXTCLK) begin
        if (!RST_n) begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          key_state_q <= 1'b0;
          press_q     <= 1'b0;
          release_q   <= 1'b0;
        end else begin
          press_q   <= 1'b0;
          release_q <= 1'b0;
          case (state_q)
            IDLE: begin
              if (!sync2_q) begin
                state_q <= PRESS_WAIT;
                cnt_q   <= '0;
              end
            end
            PRESS_WAIT: begin
              if (sync2_q) begin
                // Bounce: fall back to the released state, no event.
                state_q <= IDLE;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_MAX) begin
                state_q     <= PRESSED;
                key_state_q <= 1'b1;
                press_q     <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            PRESSED: begin
              if (sync2_q) begin
                state_q <= RELEASE_WAIT;
                cnt_q   <= '0;
              end
            end
            RELEASE_WAIT: begin
              if (!sync2_q) begin
                // Bounce: fall back to the pressed state, no event.
                state_q <= PRESSED;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_MAX) begin
                state_q     <= IDLE;
                key_state_q <= 1'b0;
                release_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end

      assign KEY_STATE[k]   = key_state_q;
      assign KEY_PRESS[k]   = press_q;
      assign KEY_RELEASE[k] = release_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Self-checking bench for key_debounce (DEBOUNCE_CYCLES = 8).
//               A run-length reference model tracks each key: a level change
//               is accepted once DEBOUNCE_CYCLES+1 consecutive synchronized
//               samples disagree with the current debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

  localparam int NK = 2;
  localparam int D  = 8;

  logic          EXTCLK = 1'b0;
  logic          RST_n  = 1'b0;
  logic [NK-1:0] KEY_n  = 2'b11;
  logic [NK-1:0] KEY_STATE;
  logic [NK-1:0] KEY_PRESS;
  logic [NK-1:0] KEY_RELEASE;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .EXTCLK      (EXTCLK),
    .RST_n       (RST_n),
    .KEY_n       (KEY_n),
    .KEY_STATE   (KEY_STATE),
    .KEY_PRESS   (KEY_PRESS),
    .KEY_RELEASE (KEY_RELEASE)
  );

  always #5 EXTCLK = ~EXTCLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NK-1:0] m_p1 = 2'b11, m_p2 = 2'b11;
  logic [NK-1:0] m_state = '0, m_press = '0, m_rel = '0;
  int            m_run[NK];

  // Observation history for property checks
  logic [NK-1:0] prev_state = '0, prev_press = '0, prev_rel = '0;
  logic          press_seen = 1'b0;
  int            press_cnt0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs the edge will sample,
  // then check the DUT 1 time unit after the edge.
  task automatic tick();
    logic [NK-1:0] s;
    logic          rst_at_edge;
    rst_at_edge = RST_n;
    if (!RST_n) begin
      m_p1 = '1; m_p2 = '1; m_state = '0; m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      s = m_p2; m_p2 = m_p1; m_p1 = KEY_n;
      m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
        if ((!s[k]) != m_state[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_run[k]   = 0;
            m_state[k] = !m_state[k];
            if (m_state[k]) m_press[k] = 1'b1;
            else            m_rel[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    @(posedge EXTCLK);
    #1;
    chk("model", {26'd0, KEY_STATE, KEY_PRESS, KEY_RELEASE}, {26'd0, m_state, m_press, m_rel});
    chk("excl", {30'd0, KEY_PRESS & KEY_RELEASE}, 32'd0);
    chk("press_width", {30'd0, KEY_PRESS & prev_press}, 32'd0);
    chk("release_width", {30'd0, KEY_RELEASE & prev_rel}, 32'd0);
    if (rst_at_edge)
      chk("toggle_per_pulse", {30'd0, KEY_STATE ^ prev_state}, {30'd0, KEY_PRESS | KEY_RELEASE});
    if (KEY_PRESS != '0) press_seen = 1'b1;
    if (KEY_PRESS[0])    press_cnt0++;
    prev_state = KEY_STATE;
    prev_press = KEY_PRESS;
    prev_rel   = KEY_RELEASE;
  endtask

  typedef struct {
    logic          rst_n;
    logic [NK-1:0] key_n;
    int            n;
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } vec_t;

  vec_t tbl[13];

  initial begin
    for (int k = 0; k < NK; k++) m_run[k] = 0;

    // {rst_n, KEY_n, cycles held, expected STATE, PRESS, RELEASE after last}
    tbl[0]  = '{1'b0, 2'b11,  3, 2'b00, 2'b00, 2'b00};  // reset
    tbl[1]  = '{1'b1, 2'b11, 20, 2'b00, 2'b00, 2'b00};  // idle after reset
    tbl[2]  = '{1'b1, 2'b10, 10, 2'b00, 2'b00, 2'b00};  // key0 low E0..E9
    tbl[3]  = '{1'b1, 2'b10,  1, 2'b01, 2'b01, 2'b00};  // E10: press
    tbl[4]  = '{1'b1, 2'b10,  1, 2'b01, 2'b00, 2'b00};  // pulse gone
    tbl[5]  = '{1'b1, 2'b11, 10, 2'b01, 2'b00, 2'b00};  // release pending
    tbl[6]  = '{1'b1, 2'b11,  1, 2'b00, 2'b00, 2'b01};  // E10: release
    tbl[7]  = '{1'b1, 2'b11,  1, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 2'b01, 11, 2'b10, 2'b10, 2'b00};  // key1 alone
    tbl[9]  = '{1'b1, 2'b00, 11, 2'b11, 2'b01, 2'b00};  // key0 joins
    tbl[10] = '{1'b1, 2'b11, 11, 2'b00, 2'b00, 2'b11};  // both released together
    tbl[11] = '{1'b1, 2'b00, 11, 2'b11, 2'b11, 2'b00};  // both pressed together
    tbl[12] = '{1'b1, 2'b11, 11, 2'b00, 2'b00, 2'b11};

    for (int i = 0; i < 13; i++) begin
      RST_n = tbl[i].rst_n;
      KEY_n = tbl[i].key_n;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d", i), {26'd0, KEY_STATE, KEY_PRESS, KEY_RELEASE},
          {26'd0, tbl[i].st, tbl[i].pr, tbl[i].rl});
    end
    repeat (5) tick();

    // Bounce rejection: 3-low / 2-high for 40 cycles, then a stable low.
    press_seen = 1'b0;
    for (int r = 0; r < 8; r++) begin
      KEY_n = 2'b10; repeat (3) tick();
      KEY_n = 2'b11; repeat (2) tick();
    end
    chk("bounce_quiet", {31'd0, press_seen}, 32'd0);
    press_cnt0 = 0;
    KEY_n = 2'b10;
    repeat (10) tick();
    chk("bounce_pre", {30'd0, KEY_STATE}, 32'd0);
    tick();
    chk("bounce_press", {28'd0, KEY_STATE, KEY_PRESS}, {28'd0, 2'b01, 2'b01});
    repeat (19) tick();
    chk("bounce_one_pulse", press_cnt0, 32'd1);
    KEY_n = 2'b11;
    repeat (15) tick();

    // Reset in the middle of PRESS_WAIT (cnt = 5 after E7), key held low.
    press_seen = 1'b0;
    KEY_n = 2'b10;
    repeat (8) tick();
    RST_n = 1'b0;
    repeat (3) tick();
    chk("rst_mid_out", {26'd0, KEY_STATE, KEY_PRESS, KEY_RELEASE}, 32'd0);
    RST_n = 1'b1;
    repeat (10) tick();
    chk("rst_mid_quiet", {31'd0, press_seen}, 32'd0);
    tick();
    chk("rst_mid_press", {28'd0, KEY_STATE, KEY_PRESS}, {28'd0, 2'b01, 2'b01});
    KEY_n = 2'b11;
    repeat (15) tick();

    // Randomized stimulus: random levels held for random lengths, rare resets.
    begin
      int cyc;
      int hold;
      cyc = 0;
      while (cyc < 10000) begin
        KEY_n = NK'($urandom);
        RST_n = ($urandom_range(0, 199) != 0);
        hold  = $urandom_range(1, 14);
        repeat (hold) tick();
        cyc += hold;
      end
    end
    RST_n = 1'b1;
    KEY_n = 2'b11;
    repeat (15) tick();
    chk("final_idle", {26'd0, KEY_STATE, KEY_PRESS, KEY_RELEASE}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Per-key synchronizer and debouncer for the DE0-Nano KEY pushbuttons. It sits directly upstream of the counter/LED top level. It converts raw, bouncy, asynchronous active-low KEY_n inputs into clean active-high levels and single-cycle press/release event pulses, all in the EXTCLK domain. The downstream logic uses KEY_STATE/KEY_PRESS instead of sampling KEY_n directly.

## Interface
- NUM_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: stable cycles required before a level change is accepted (10 ms at 50 MHz). Legal range ≥ 2; benches override it to a small value.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of the per-key counter (derived, localparam).

Ports:
- EXTCLK  in  1  system clock, 50 MHz; all logic on its rising edge.
- RST_n  in  1  reset, synchronous, active-low.
- KEY_n  in  NUM_KEYS  raw pushbutton inputs, asynchronous, active-low (0 = pressed).
- KEY_STATE  out  NUM_KEYS  debounced level, active-high (1 = pressed).
- KEY_PRESS  out  NUM_KEYS  one-cycle pulse when KEY_STATE rises.
- KEY_RELEASE  out  NUM_KEYS  one-cycle pulse when KEY_STATE falls.

## Operation
- Each key has its own identical logic path: a 2-flop synchronizer (sync1→sync2), a 4-state FSM and a CNT_W-bit counter. Keys never interact.
- The synchronizer flops reset to 1 (released). The FSM only ever looks at sync2.
- FSM states: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - sync2 = 0 → PRESS_WAIT, cnt ← 0.
  - Otherwise stay.
- PRESS_WAIT:
  - sync2 = 1 → IDLE, cnt ← 0, no pulse (glitch rejected).
  - sync2 = 0 and cnt = DEBOUNCE_CYCLES−1 → PRESSED, KEY_STATE ← 1, KEY_PRESS ← 1.
  - Otherwise cnt ← cnt+1.
- PRESSED:
  - sync2 = 1 → RELEASE_WAIT, cnt ← 0.
  - Otherwise stay.
- RELEASE_WAIT: the mirror of PRESS_WAIT.
  - sync2 = 0 → PRESSED, cnt ← 0, no pulse.
  - sync2 = 1 and cnt = DEBOUNCE_CYCLES−1 → IDLE, KEY_STATE ← 0, KEY_RELEASE ← 1.
  - Otherwise cnt ← cnt+1.
- KEY_PRESS and KEY_RELEASE are registered and high for exactly one cycle; they are 0 in all other cycles.
- KEY_PRESS and KEY_RELEASE are never both high for the same key.
- The counter never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around. It only counts inside the *_WAIT states.
- Any bounce inside a *_WAIT window restarts qualification from the opposite stable state.
- Simultaneous edges on several keys are handled independently in the same cycle.

## Timing
- Reset: RST_n sampled low at an edge forces the following values; reset has priority over all other logic:
  - sync1 = sync2 = 1
  - state = IDLE, cnt = 0
  - KEY_STATE = 0, KEY_PRESS = 0, KEY_RELEASE = 0
- Reset mid-operation: any WAIT progress is discarded and no pulse is emitted for the aborted transition.
- Key held through reset: after RST_n rises, a held key is debounced as a new press and yields a KEY_PRESS pulse.
- Press latency, with edge E0 being the first edge that samples KEY_n low:
  - sync2 = 0 after E1.
  - PRESS_WAIT entered at E2.
  - KEY_STATE and KEY_PRESS go high after edge E(DEBOUNCE_CYCLES+2).
  - This requires KEY_n low at edges E0..E(DEBOUNCE_CYCLES).
- Release latency is identical, counted from the first edge that samples KEY_n high.
- Minimum accepted pulse width is DEBOUNCE_CYCLES+1 consecutive sync2 samples. Anything shorter produces no output change.

## Test plan
- Reset: hold RST_n=0 for 3 cycles with KEY_n=2'b11 → all outputs 0. Release reset, idle 20 cycles → outputs stay 0.
- Clean press/release (DEBOUNCE_CYCLES=8): KEY_n[0]=0 sampled at edge E0 → KEY_STATE[0]=1 and KEY_PRESS[0]=1 for exactly one cycle after edge E10. Release → KEY_RELEASE[0] one cycle after 10 edges, KEY_STATE[0]=0.
- Bounce rejection: toggle KEY_n[0] with low pulses of 3 cycles and gaps of 2 cycles for 40 cycles, then hold low → no pulse during bouncing. Exactly one KEY_PRESS 10 edges after the final stable low.
- Independent keys: press KEY_n[1] alone, then both keys on the same edge → KEY_STATE[0] unaffected by KEY[1]. Simultaneous press gives KEY_PRESS=2'b11 on the same cycle.
- Reset mid-debounce: assert RST_n=0 at cnt=5 in PRESS_WAIT while the key stays low → no pulse during reset. After reset, KEY_PRESS arrives a full DEBOUNCE_CYCLES+2 edges after RST_n deasserts.
- Pulse exclusivity: random KEY_n stimulus for 10k cycles → assert that KEY_PRESS&KEY_RELEASE is always 0. Also check that each pulse lasts 1 cycle and that KEY_STATE toggles exactly once per pulse.
